// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one L1 I-cache read at a time and buffers returned words in a fetch queue.
// Optional stall-cycle performance counter is enabled by defining FETCH_PERF_CNT_EN.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned FQ_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         redirect_valid,
    input  logic [31:0]                  redirect_pc,
    output logic                         ic_req,
    output logic [31:0]                  ic_addr,
    input  logic                         ic_resp_valid,
    input  logic [31:0]                  ic_resp_data,
    output logic                         dec_valid,
    output logic [31:0]                  dec_pc,
    output logic [31:0]                  dec_instr,
    input  logic                         dec_ready,
    output logic [$clog2(FQ_DEPTH):0]    fq_count
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                  stall_cycles
`endif
);

    localparam int unsigned PW = $clog2(FQ_DEPTH);
    localparam logic [PW:0]   FULL     = FQ_DEPTH[PW:0];
    localparam logic [PW:0]   CNT_ZERO = {(PW+1){1'b0}};
    localparam logic [PW:0]   CNT_ONE  = {{PW{1'b0}}, 1'b1};
    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};

    localparam logic [1:0] ST_ISSUE = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DROP  = 2'd2;

    logic [1:0]    state_r;
    logic [1:0]    state_s;
    logic [31:0]   pc_r;
    logic [31:0]   pc_s;
    logic [31:0]   addr_r;
    logic          req_r;
    logic          push_s;
    logic          pop_s;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [PW:0]   count_r;
    logic [31:0]   mem_pc_r    [FQ_DEPTH];
    logic [31:0]   mem_instr_r [FQ_DEPTH];

    // Next-state, next-PC and queue push/pop decisions; a redirect overrides everything else.
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        push_s  = 1'b0;
        pop_s   = 1'b0;
        if (redirect_valid) begin
            pc_s = redirect_pc & 32'hFFFF_FFFC;
            // A response landing with the redirect completes the old request, so nothing is left to drop.
            if (state_r == ST_ISSUE || ic_resp_valid) begin
                state_s = ST_ISSUE;
            end else begin
                state_s = ST_DROP;
            end
        end else begin
            pop_s = (count_r != CNT_ZERO) && dec_ready;
            case (state_r)
                ST_ISSUE: begin
                    if (count_r < FULL) begin
                        state_s = ST_WAIT;
                    end else begin
                        state_s = ST_ISSUE;
                    end
                end
                ST_WAIT: begin
                    if (ic_resp_valid) begin
                        push_s  = 1'b1;
                        pc_s    = pc_r + 32'd4;
                        state_s = ST_ISSUE;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end
                ST_DROP: begin
                    if (ic_resp_valid) begin
                        state_s = ST_ISSUE;
                    end else begin
                        state_s = ST_DROP;
                    end
                end
                default: begin
                    state_s = ST_ISSUE;
                end
            endcase
        end
    end

    // Control state, PC and the request address held stable while a request is outstanding.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_ISSUE;
            pc_r    <= RESET_PC;
            addr_r  <= RESET_PC;
            req_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            req_r   <= (state_s != ST_ISSUE);
            if (state_s == ST_ISSUE || state_r == ST_ISSUE) begin
                addr_r <= pc_s;
            end else begin
                addr_r <= addr_r;
            end
        end
    end

    // Fetch-queue circular buffer: pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr_r <= PTR_ZERO;
            wr_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            for (int i = 0; i < FQ_DEPTH; i++) begin
                mem_pc_r[i]    <= 32'h0000_0000;
                mem_instr_r[i] <= 32'h0000_0000;
            end
        end else if (redirect_valid) begin
            rd_ptr_r <= PTR_ZERO;
            wr_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                mem_pc_r[wr_ptr_r]    <= addr_r;
                mem_instr_r[wr_ptr_r] <= ic_resp_data;
                wr_ptr_r              <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating count of cycles spent unable to issue because the queue is full.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cycles <= 32'h0000_0000;
        end else if (state_r == ST_ISSUE && count_r == FULL && stall_cycles != 32'hFFFF_FFFF) begin
            stall_cycles <= stall_cycles + 32'd1;
        end else begin
            stall_cycles <= stall_cycles;
        end
    end
`endif

    assign ic_req    = req_r;
    assign ic_addr   = addr_r;
    assign fq_count  = count_r;
    assign dec_valid = (count_r != CNT_ZERO);
    assign dec_pc    = dec_valid ? mem_pc_r[rd_ptr_r]    : 32'h0000_0000;
    assign dec_instr = dec_valid ? mem_instr_r[rd_ptr_r] : 32'h0000_0000;

endmodule
